// File: rtl/online_pkg.sv
// Shared definitions for the online (MSD-first, signed-digit) arithmetic stages:
// digit rail encodings, converter FSM state type and the digit decoder.
package online_pkg;

    // {zp, zn} rail encodings; 2'b11 is also legal and decodes to zero.
    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ZERO = 2'b00;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } otf_state_t;

    // d = zp - zn as a 2-bit signed value (+1, 0, -1).
    function automatic logic signed [1:0] decode_digit(input logic zp, input logic zn);
        logic signed [1:0] d;
        case ({zp, zn})
            DIG_POS: d = 2'sb01;
            DIG_NEG: d = 2'sb11;
            default: d = 2'sb00;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/otf_step.sv
// One on-the-fly conversion step. Keeps the pair Q (value so far) and
// QM (Q - 1) so a negative digit never needs a borrow chain: each step is a
// shift plus a choice between the two registers. With first=1 the step starts
// from Q=0, QM=-1 regardless of the incoming register values.
import online_pkg::*;

module otf_step #(
    parameter int W = 17
) (
    input  logic [W-1:0]      q,
    input  logic [W-1:0]      qm,
    input  logic signed [1:0] d,
    input  logic              first,
    output logic [W-1:0]      q_nxt,
    output logic [W-1:0]      qm_nxt
);

    logic [W-1:0] q_base;
    logic [W-1:0] qm_base;

    // Select the starting pair, then shift in the digit (mod 2^W).
    always_comb begin
        q_base  = first ? '0 : q;
        qm_base = first ? '1 : qm;
        case (d)
            2'sb01: begin
                q_nxt  = {q_base[W-2:0], 1'b1};
                qm_nxt = {q_base[W-2:0], 1'b0};
            end
            2'sb11: begin
                q_nxt  = {qm_base[W-2:0], 1'b1};
                qm_nxt = {qm_base[W-2:0], 1'b0};
            end
            default: begin
                q_nxt  = {q_base[W-2:0], 1'b0};
                qm_nxt = {qm_base[W-2:0], 1'b1};
            end
        endcase
    end

endmodule

// File: rtl/online_otf_converter.sv
// Converts the online adder's serial redundant digit stream (MSD first) into a
// two's-complement word of DIGITS+1 bits without a carry-propagate adder.
// Optional macro ONLINE_OTF_SAT_EN: saturate the result to the DIGITS-bit
// signed range and flag clipping on out_ovf; otherwise out_ovf is 0.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. out_data/out_valid are held stable until that transfer. in_ready drops
// only when the final digit of a word would overwrite a result not yet taken.
import online_pkg::*;

module online_otf_converter #(
    parameter int DIGITS = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_first,
    input  logic              in_zp,
    input  logic              in_zn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DIGITS:0]   out_data,
    output logic              out_abort,
    output logic              out_ovf
);

    localparam int OUT_W = DIGITS + 1;
    localparam int CNT_W = $clog2(DIGITS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    otf_state_t        state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [OUT_W-1:0]  q, qm, q_nxt, qm_nxt;
    logic [OUT_W-1:0]  fin_data;
    logic              fin_ovf;
    logic              accept;
    logic              step_en;
    logic              load;
    logic              abort_nxt;
    logic signed [1:0] d;

    assign d        = decode_digit(in_zp, in_zn);
    assign in_ready = !(state == ACC && cnt == LAST && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;

    otf_step #(.W(OUT_W)) u_step (
        .q      (q),
        .qm     (qm),
        .d      (d),
        .first  (in_first),
        .q_nxt  (q_nxt),
        .qm_nxt (qm_nxt)
    );

`ifdef ONLINE_OTF_SAT_EN
    // Clip to the DIGITS-bit signed range: overflow shows as the top two bits differing.
    always_comb begin
        fin_data = q_nxt;
        fin_ovf  = 1'b0;
        if (q_nxt[OUT_W-1] != q_nxt[OUT_W-2]) begin
            fin_ovf  = 1'b1;
            fin_data = q_nxt[OUT_W-1] ? {2'b11, {(OUT_W-2){1'b0}}}
                                      : {2'b00, {(OUT_W-2){1'b1}}};
        end
    end
`else
    assign fin_data = q_nxt;
    assign fin_ovf  = 1'b0;
`endif

    // Next-state logic: word start, accumulate, abort/restart, completion.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        step_en   = 1'b0;
        load      = 1'b0;
        abort_nxt = 1'b0;
        if (accept) begin
            case (state)
                IDLE: begin
                    if (in_first) begin
                        step_en   = 1'b1;
                        cnt_nxt   = CNT_W'(1);
                        state_nxt = ACC;
                    end
                end
                ACC: begin
                    step_en = 1'b1;
                    if (in_first) begin
                        abort_nxt = 1'b1;
                        cnt_nxt   = CNT_W'(1);
                    end else if (cnt == LAST) begin
                        load      = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, digit counter and the Q/QM conversion pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            q     <= '0;
            qm    <= '1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (step_en) begin
                q  <= q_nxt;
                qm <= qm_nxt;
            end
        end
    end

    // Output register: load a finished word, clear valid once it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_abort <= 1'b0;
        end else begin
            out_abort <= abort_nxt;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= fin_data;
                out_ovf   <= fin_ovf;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_online_otf_converter.sv
// Directed bench for online_otf_converter with DIGITS=4 (5-bit results).
module tb_online_otf_converter;

    localparam int DIGITS = 4;
    localparam int OUT_W  = DIGITS + 1;

    localparam logic [1:0] P  = 2'b10;
    localparam logic [1:0] N  = 2'b01;
    localparam logic [1:0] Z  = 2'b00;
    localparam logic [1:0] Z2 = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic             in_first;
    logic             in_zp;
    logic             in_zn;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_abort;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    online_otf_converter #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_first  (in_first),
        .in_zp     (in_zp),
        .in_zn     (in_zn),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_abort (out_abort),
        .out_ovf   (out_ovf)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one digit for one cycle; inputs change 1 time unit after the edge.
    task automatic drive(input logic [1:0] dig, input logic first);
        in_valid = 1'b1;
        in_zp    = dig[1];
        in_zn    = dig[0];
        in_first = first;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_zp    = 1'b0;
        in_zn    = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_zp     = 1'b0;
        in_zn     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 5'b00000) begin errors++; $display("FAIL reset_data got %b want 00000", out_data); end
        checks++; if (out_abort !== 1'b0) begin errors++; $display("FAIL reset_abort got %b want 0", out_abort); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
        rst_n = 1'b1;
        idle_cycle();
    endtask

    // +1,0,-1,+1 -> 7.
    task automatic test_basic();
        out_ready = 1'b1;
        drive(P, 1'b1);
        drive(Z, 1'b0);
        drive(N, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", out_valid); end
        drive(P, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 5'b00111) begin errors++; $display("FAIL basic_data got %b want 00111", out_data); end
        checks++; if (out_abort !== 1'b0) begin errors++; $display("FAIL basic_abort got %b want 0", out_abort); end
        checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", out_ovf); end
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %b want 0", out_valid); end
    endtask

    // -1,-1,-1,-1 -> -15, or -8 with overflow when saturating.
    task automatic test_negative();
        logic [OUT_W-1:0] exp_data;
        logic             exp_ovf;
`ifdef ONLINE_OTF_SAT_EN
        exp_data = 5'b11000;
        exp_ovf  = 1'b1;
`else
        exp_data = 5'b10001;
        exp_ovf  = 1'b0;
`endif
        out_ready = 1'b1;
        drive(N, 1'b1);
        drive(N, 1'b0);
        drive(N, 1'b0);
        drive(N, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL neg_valid got %b want 1", out_valid); end
        checks++; if (out_data !== exp_data) begin errors++; $display("FAIL neg_data got %b want %b", out_data, exp_data); end
        checks++; if (out_ovf !== exp_ovf) begin errors++; $display("FAIL neg_ovf got %b want %b", out_ovf, exp_ovf); end
        idle_cycle();
    endtask

    // Word A (7) held with out_ready=0 while word B (0,0,0,+1 = 1) overlaps and stalls.
    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(P, 1'b1);
        drive(Z, 1'b0);
        drive(N, 1'b0);
        drive(P, 1'b0);
        checks++; if (out_data !== 5'b00111) begin errors++; $display("FAIL b2b_a_data got %b want 00111", out_data); end
        drive(Z, 1'b1);
        drive(Z, 1'b0);
        drive(Z, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_hold_valid got %b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_ready got %b want 0", in_ready); end
        in_valid = 1'b1;
        in_zp    = 1'b1;
        in_zn    = 1'b0;
        in_first = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_data !== 5'b00111) begin errors++; $display("FAIL b2b_hold_data got %b want 00111", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_still_stalled got %b want 0", in_ready); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_release_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_zp    = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_b_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 5'b00001) begin errors++; $display("FAIL b2b_b_data got %b want 00001", out_data); end
        idle_cycle();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_b_drain got %b want 0", out_valid); end
    endtask

    // in_first on the 3rd digit aborts; the restarted +1,+1,+1,+1 gives 15.
    task automatic test_abort();
        logic [OUT_W-1:0] exp_data;
        logic             exp_ovf;
`ifdef ONLINE_OTF_SAT_EN
        exp_data = 5'b00111;
        exp_ovf  = 1'b1;
`else
        exp_data = 5'b01111;
        exp_ovf  = 1'b0;
`endif
        out_ready = 1'b1;
        drive(P, 1'b1);
        drive(P, 1'b0);
        checks++; if (out_abort !== 1'b0) begin errors++; $display("FAIL abort_early got %b want 0", out_abort); end
        drive(P, 1'b1);
        checks++; if (out_abort !== 1'b1) begin errors++; $display("FAIL abort_pulse got %b want 1", out_abort); end
        drive(P, 1'b0);
        checks++; if (out_abort !== 1'b0) begin errors++; $display("FAIL abort_one_cycle got %b want 0", out_abort); end
        drive(P, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_complete got %b want 0", out_valid); end
        drive(P, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL abort_valid got %b want 1", out_valid); end
        checks++; if (out_data !== exp_data) begin errors++; $display("FAIL abort_data got %b want %b", out_data, exp_data); end
        checks++; if (out_ovf !== exp_ovf) begin errors++; $display("FAIL abort_ovf got %b want %b", out_ovf, exp_ovf); end
        idle_cycle();
    endtask

    // Digits without a leading in_first are dropped; (1,1) decodes as zero.
    task automatic test_ignore_and_zero();
        logic [OUT_W-1:0] exp_data;
        logic             exp_ovf;
`ifdef ONLINE_OTF_SAT_EN
        exp_data = 5'b00111;
        exp_ovf  = 1'b1;
`else
        exp_data = 5'b01000;
        exp_ovf  = 1'b0;
`endif
        out_ready = 1'b1;
        drive(P, 1'b0);
        drive(N, 1'b0);
        drive(P, 1'b0);
        drive(N, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ignore_valid got %b want 0", out_valid); end
        drive(P, 1'b1);
        drive(Z2, 1'b0);
        drive(Z2, 1'b0);
        drive(Z, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero11_valid got %b want 1", out_valid); end
        checks++; if (out_data !== exp_data) begin errors++; $display("FAIL zero11_data got %b want %b", out_data, exp_data); end
        checks++; if (out_ovf !== exp_ovf) begin errors++; $display("FAIL zero11_ovf got %b want %b", out_ovf, exp_ovf); end
        idle_cycle();
    endtask

    // Reset after two digits loses the partial word silently.
    task automatic test_reset_mid();
        out_ready = 1'b1;
        drive(P, 1'b1);
        drive(N, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
        idle_cycle();
        rst_n = 1'b1;
        checks++; if (out_abort !== 1'b0) begin errors++; $display("FAIL rstmid_abort got %b want 0", out_abort); end
        idle_cycle();
        drive(Z, 1'b1);
        checks++; if (out_abort !== 1'b0) begin errors++; $display("FAIL rstmid_restart_abort got %b want 0", out_abort); end
        drive(Z, 1'b0);
        drive(Z, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_spurious_valid got %b want 0", out_valid); end
        drive(P, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid_end got %b want 1", out_valid); end
        checks++; if (out_data !== 5'b00001) begin errors++; $display("FAIL rstmid_data got %b want 00001", out_data); end
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_back_to_back();
        test_abort();
        test_ignore_and_zero();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
